sdram_rd_line_fetch: RTL
========================

Name: sdram_rd_line_fetch

Overview:
- SDRAM-side read fetcher that services the line-RAM refill request of the scaler read-address block in the EPHOTO display path.
- On a request level, it issues fixed-length SDRAM read bursts from a running frame address and streams the returned words into the line RAM as write enable plus data.
- When the programmed segment is complete, it pulses the request-clear back to the address block.
- It sits between the SDRAM controller read port and the line-RAM write side.

Parameters:
- BURST_LEN, 8: words per SDRAM read command; power of 2, range 2..256.
- FETCH_WORDS, 160: words fetched per request; must be a multiple of BURST_LEN.
- FRAME_WORDS, 384000: words per frame (800x480); the address wraps after this many words.
- BASE_ADDR, 23'd0: SDRAM word address of the frame buffer start.

Ports:
- iCLK  in  1  single clock for all logic.
- iRST  in  1  synchronous, active-high reset.
- iREQ  in  1  line-RAM refill request level; held high until oREQ_CLR.
- iFRAME_START  in  1  one-cycle pulse at vertical sync; rewinds the frame address.
- oREQ_CLR  out  1  one-cycle pulse that clears the upstream request.
- oRD_REQ  out  1  SDRAM read command valid.
- oRD_ADDR  out  23  SDRAM word address of the current burst.
- oRD_LEN  out  9  burst length, constant BURST_LEN.
- iRD_ACK  in  1  SDRAM controller accepts the command in the same cycle.
- iRD_VALID  in  1  read data beat valid.
- iRD_DATA  in  16  read data.
- oLRAM_WE  out  1  line-RAM write enable; drives the write-address counter enable.
- oLRAM_DATA  out  16  line-RAM write data.
- oBUSY  out  1  high whenever the state is not IDLE.
- oERR  out  1  sticky error flag: a read beat arrived outside DATA.

Behaviour:
- Reset, sampled on the iCLK edge, sets:
  - state IDLE;
  - frame address BASE_ADDR, word counters 0, frame-start pending flag 0;
  - outputs: oRD_REQ 0, oRD_ADDR BASE_ADDR, oRD_LEN BURST_LEN, oREQ_CLR 0, oLRAM_WE 0, oLRAM_DATA 0, oBUSY 0, oERR 0.
- Reset mid-burst abandons the burst. Beats arriving afterwards while in IDLE set oERR.
- State IDLE:
  - If a frame-start is pending, the frame address is rewound to BASE_ADDR and the flag cleared.
  - If iREQ=1, the next state is CMD and the segment counter is cleared to 0.
- State CMD:
  - oRD_REQ=1 and oRD_ADDR holds the current frame address, stable until acknowledged.
  - On iRD_ACK=1: the frame address advances by BURST_LEN, the beat counter clears, and the next state is DATA.
  - oRD_REQ deasserts the cycle after acknowledgement.
  - Address wrap: if the advanced address would reach BASE_ADDR+FRAME_WORDS, it becomes BASE_ADDR instead.
- State DATA:
  - Each iRD_VALID beat is registered: oLRAM_WE=1 and oLRAM_DATA=iRD_DATA one cycle later (latency 1). The beat counter and segment counter each increment.
  - On the beat that makes the beat counter equal BURST_LEN:
    - next state CLR if the segment counter reaches FETCH_WORDS;
    - otherwise next state CMD.
  - Back-to-back commands are allowed: CMD can follow DATA with zero idle cycles.
- State CLR: oREQ_CLR=1 for exactly one cycle, then HOLD.
- State HOLD: iREQ is ignored for one cycle so the upstream request has time to drop; then IDLE.
  - A request still high when IDLE is re-entered starts a new fetch.
- iFRAME_START:
  - In IDLE it rewinds the address immediately, in the same cycle.
  - In any other state it sets the pending flag. The fetch in progress completes with the old addresses, and the rewind is applied in IDLE.
  - A pulse coincident with the entry into CLR is still recorded.
- iRD_VALID outside DATA: the data is dropped, oLRAM_WE stays 0, and oERR is set. oERR clears only on reset.
- Segment counter is 16 bits and beat counter is 9 bits; neither wraps within a segment.
- Frame address arithmetic is 23-bit unsigned.

Test Plan:
- Reset, then iREQ=1 with default parameters -> 20 commands at addresses 0, 8, ..., 152; exactly 160 oLRAM_WE pulses with data matching input order; one oREQ_CLR pulse; then IDLE.
- A second request after the first completes -> first command address 160; after 2400 requests (one frame) the next command address wraps to 0.
- iFRAME_START pulsed during the 5th burst -> the remaining 15 bursts continue from 40 upward; the next request starts at 0.
- iRD_ACK delayed by 7 cycles -> oRD_REQ and oRD_ADDR held stable for all 8 cycles; only one address increment occurs.
- iREQ held high through CLR/HOLD -> exactly one cycle gap in HOLD, then a new fetch starts at the next address; no double clear.
- iRD_VALID pulsed in IDLE -> oERR=1 sticky, no oLRAM_WE; iRST=1 for one cycle -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sdram_rd_line_fetch.sv
// rtl/sdram_rd_line_fetch.sv - SDRAM read burst fetcher refilling the scaler line RAM
// Issues BURST_LEN reads from a wrapping frame address until FETCH_WORDS words are written.
module sdram_rd_line_fetch #(
  parameter int          BURST_LEN   = 8,
  parameter int          FETCH_WORDS = 160,
  parameter int          FRAME_WORDS = 384000,
  parameter logic [22:0] BASE_ADDR   = 23'd0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ,
  input  logic        iFRAME_START,
  output logic        oREQ_CLR,
  output logic        oRD_REQ,
  output logic [22:0] oRD_ADDR,
  output logic [8:0]  oRD_LEN,
  input  logic        iRD_ACK,
  input  logic        iRD_VALID,
  input  logic [15:0] iRD_DATA,
  output logic        oLRAM_WE,
  output logic [15:0] oLRAM_DATA,
  output logic        oBUSY,
  output logic        oERR
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_CLR, ST_HOLD} state_e;

  localparam logic [22:0] BURST_A = 23'(BURST_LEN);
  localparam logic [22:0] END_A   = BASE_ADDR + 23'(FRAME_WORDS);
  localparam logic [8:0]  BURST_B = 9'(BURST_LEN);
  localparam logic [15:0] FETCH_S = 16'(FETCH_WORDS);

  state_e      state_q, state_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] seg_q, seg_d;
  logic [8:0]  beat_q, beat_d;
  logic        pend_q, pend_d;
  logic        we_q, we_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  logic [22:0] addr_inc;
  logic [15:0] seg_inc;
  logic [8:0]  beat_inc;

  assign addr_inc = addr_q + BURST_A;
  assign seg_inc  = seg_q + 16'd1;
  assign beat_inc = beat_q + 9'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seg_d   = seg_q;
    beat_d  = beat_q;
    pend_d  = pend_q;
    we_d    = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    // A frame start outside IDLE is deferred so the running fetch keeps its addresses.
    if (iFRAME_START && state_q != ST_IDLE) pend_d = 1'b1;
    if (iRD_VALID && state_q != ST_DATA) err_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || iFRAME_START) begin
          addr_d = BASE_ADDR;
          pend_d = 1'b0;
        end
        if (iREQ) begin
          state_d = ST_CMD;
          seg_d   = 16'd0;
        end
      end
      ST_CMD: begin
        if (iRD_ACK) begin
          addr_d  = (addr_inc >= END_A) ? BASE_ADDR : addr_inc;
          beat_d  = 9'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (iRD_VALID) begin
          we_d   = 1'b1;
          data_d = iRD_DATA;
          beat_d = beat_inc;
          seg_d  = seg_inc;
          if (beat_inc == BURST_B) state_d = (seg_inc == FETCH_S) ? ST_CLR : ST_CMD;
        end
      end
      ST_CLR:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      seg_q   <= 16'd0;
      beat_q  <= 9'd0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seg_q   <= seg_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign oRD_REQ    = (state_q == ST_CMD);
  assign oRD_ADDR   = addr_q;
  assign oRD_LEN    = BURST_B;
  assign oREQ_CLR   = (state_q == ST_CLR);
  assign oLRAM_WE   = we_q;
  assign oLRAM_DATA = data_q;
  assign oBUSY      = (state_q != ST_IDLE);
  assign oERR       = err_q;

endmodule
